// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile sequencer: state encoding and
// parameter defaults.
package tpu_pkg;

  localparam int DEFAULT_ADDRESSSIZE = 10;
  localparam int DEFAULT_MATRIX_SIZE = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LATCH_W,
    STREAM,
    DRAIN
  } seq_state_t;

  // UB read + input skew + array traversal + output deskew.
  function automatic int default_pipe_lat(input int matrix_size);
    return 3 * matrix_size;
  endfunction

endpackage

// File: rtl/tpu_valid_delay.sv
// Single-bit DEPTH-stage shift register that aligns a UB read strobe with
// the result vector it produces at the result SRAM input.
module tpu_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift the strobe one stage per clock; reset drops all in-flight strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's
      // old value, so the for-loop order does not matter.
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tile control core: optional weight load from the weight FIFO, N-vector
// stream from the unified buffer, and aligned writeback to the result SRAM.
// Optional busy-cycle perf counter enabled by macro TPU_SEQ_PERF_CNT_EN.
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE = DEFAULT_ADDRESSSIZE,
  parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
  parameter int PIPE_LAT    = default_pipe_lat(MATRIX_SIZE),
  parameter int CNT_BW      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   weight_reuse,
  input  logic [ADDRESSSIZE:0]   num_rows,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic                   we_rl,
  output logic                   ub_rd_en,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
`ifdef TPU_SEQ_PERF_CNT_EN
  output logic [CNT_BW-1:0]      cycle_count,
`endif
  output logic                   done
);

  seq_state_t state, next_state;

  logic [ADDRESSSIZE:0]   num_rows_q;
  logic [ADDRESSSIZE-1:0] src_q;
  logic [ADDRESSSIZE-1:0] dst_q;
  logic [ADDRESSSIZE:0]   rd_idx;
  logic [ADDRESSSIZE:0]   wr_idx;
  logic [ADDRESSSIZE:0]   last_idx;
  logic                   accept;
  logic                   done_next;
  logic                   busy_next;

  assign last_idx = num_rows_q - (ADDRESSSIZE+1)'(1);
  assign ub_addr  = src_q + rd_idx[ADDRESSSIZE-1:0];
  assign res_addr = dst_q + wr_idx[ADDRESSSIZE-1:0];
  assign busy_next = (next_state != IDLE) || done_next;

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    accept     = 1'b0;
    done_next  = 1'b0;
    fifo_rd_en = 1'b0;
    we_rl      = 1'b0;
    ub_rd_en   = 1'b0;
    case (state)
      IDLE: begin
        // busy is still high in the done cycle; a start there is ignored.
        if (start && !busy) begin
          accept = 1'b1;
          if (num_rows == '0)   done_next  = 1'b1;
          else if (weight_reuse) next_state = STREAM;
          else                   next_state = LOAD_W;
        end
      end
      LOAD_W: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) next_state = LATCH_W;
      end
      LATCH_W: begin
        we_rl      = 1'b1;
        next_state = STREAM;
      end
      STREAM: begin
        ub_rd_en = 1'b1;
        if (rd_idx == last_idx) next_state = DRAIN;
      end
      DRAIN: begin
        if (res_we && (wr_idx == last_idx)) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, handshake flags, tile descriptor and read/write indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      num_rows_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rd_idx     <= '0;
      wr_idx     <= '0;
    end else begin
      state <= next_state;
      busy  <= busy_next;
      done  <= done_next;
      if (accept) begin
        num_rows_q <= num_rows;
        src_q      <= src_base;
        dst_q      <= dst_base;
        rd_idx     <= '0;
        wr_idx     <= '0;
      end else begin
        if (ub_rd_en) rd_idx <= rd_idx + (ADDRESSSIZE+1)'(1);
        if (res_we)   wr_idx <= wr_idx + (ADDRESSSIZE+1)'(1);
      end
    end
  end

  tpu_valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .d   (ub_rd_en),
    .q   (res_we)
  );

`ifdef TPU_SEQ_PERF_CNT_EN
  logic [CNT_BW-1:0] perf_cnt;
  logic [CNT_BW-1:0] perf_inc;

  assign perf_inc = (perf_cnt == '1) ? perf_cnt : perf_cnt + CNT_BW'(1);

  // Saturating busy-cycle counter; the done cycle's own count is included
  // in the value published to cycle_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt    <= '0;
      cycle_count <= '0;
    end else begin
      if (accept)    perf_cnt <= '0;
      else if (busy) perf_cnt <= perf_inc;
      if (done) cycle_count <= perf_inc;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed self-checking bench for tpu_tile_sequencer (MATRIX_SIZE=4,
// PIPE_LAT=12, ADDRESSSIZE=10). Cycle 0 is the cycle in which start is high.
module tb_tpu_tile_sequencer;

  localparam int AW  = 10;
  localparam int LAT = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          weight_reuse;
  logic [AW:0]   num_rows;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          we_rl;
  logic          ub_rd_en;
  logic [AW-1:0] ub_addr;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic          busy;
  logic          done;
`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0]   cycle_count;
`endif

  int errors = 0;
  int checks = 0;
  int done_cyc;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(
    .ADDRESSSIZE (AW),
    .MATRIX_SIZE (4),
    .PIPE_LAT    (LAT),
    .CNT_BW      (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .weight_reuse (weight_reuse),
    .num_rows     (num_rows),
    .src_base     (src_base),
    .dst_base     (dst_base),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .we_rl        (we_rl),
    .ub_rd_en     (ub_rd_en),
    .ub_addr      (ub_addr),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .busy         (busy),
`ifdef TPU_SEQ_PERF_CNT_EN
    .cycle_count  (cycle_count),
`endif
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    check({tag, "_we_rl"},      we_rl,      0);
    check({tag, "_ub_rd_en"},   ub_rd_en,   0);
    check({tag, "_ub_addr"},    ub_addr,    0);
    check({tag, "_res_we"},     res_we,     0);
    check({tag, "_res_addr"},   res_addr,   0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
`ifdef TPU_SEQ_PERF_CNT_EN
    check({tag, "_cycle_count"}, cycle_count, 0);
`endif
  endtask

  // Runs one tile from an idle sequencer, checking every strobe each cycle
  // against the hand-derived timeline. stall = cycles of fifo_empty in LOAD_W;
  // ign = also pulse start mid-tile and in the done cycle (must be ignored).
  task automatic run_tile(input string tag, input logic reuse, input int n,
                          input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int stall, input bit ign, output int got_done);
    int t_pop, t_rd0, t_wr0, t_done, writes;
    logic [AW-1:0] ea;
    bit exp_rd, exp_wr;
    t_pop  = reuse ? -1 : 1 + stall;
    t_rd0  = reuse ? 1 : t_pop + 2;
    t_wr0  = t_rd0 + LAT;
    t_done = (n == 0) ? 1 : t_wr0 + n;
    writes = 0;
    got_done = -1;
    start = 1'b1; weight_reuse = reuse; num_rows = (AW+1)'(n);
    src_base = src; dst_base = dst; fifo_empty = 1'b0;
    for (int cyc = 1; cyc <= t_done + 2; cyc++) begin
      tick();
      start = 1'b0;
      if (ign && (cyc == 4 || cyc == t_done)) begin
        start = 1'b1; weight_reuse = 1'b0; num_rows = 11'd7; src_base = 10'h155; dst_base = 10'h0AA;
      end
      fifo_empty = (cyc <= stall);
      #1;
      exp_rd = (n > 0) && cyc >= t_rd0 && cyc < t_rd0 + n;
      exp_wr = (n > 0) && cyc >= t_wr0 && cyc < t_wr0 + n;
      check($sformatf("%s_c%0d_fifo_rd_en", tag, cyc), fifo_rd_en, (n > 0 && cyc == t_pop));
      check($sformatf("%s_c%0d_we_rl", tag, cyc), we_rl, (n > 0 && t_pop > 0 && cyc == t_pop + 1));
      check($sformatf("%s_c%0d_ub_rd_en", tag, cyc), ub_rd_en, exp_rd);
      check($sformatf("%s_c%0d_res_we", tag, cyc), res_we, exp_wr);
      check($sformatf("%s_c%0d_busy", tag, cyc), busy, (cyc <= t_done));
      check($sformatf("%s_c%0d_done", tag, cyc), done, (cyc == t_done));
      if (exp_rd) begin
        ea = src + AW'(cyc - t_rd0);
        check($sformatf("%s_c%0d_ub_addr", tag, cyc), ub_addr, ea);
      end
      if (exp_wr) begin
        ea = dst + AW'(cyc - t_wr0);
        check($sformatf("%s_c%0d_res_addr", tag, cyc), res_addr, ea);
      end
      if (res_we) writes++;
      if (done && got_done < 0) got_done = cyc;
    end
    start = 1'b0;
    check({tag, "_write_count"}, writes, n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; weight_reuse = 1'b0; num_rows = '0;
    src_base = '0; dst_base = '0; fifo_empty = 1'b0;
    #2;
    check_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic tile: pop c1, reload c2, reads c3-5, writes c15-17, done c18.
    run_tile("basic", 1'b0, 3, 10'h010, 10'h200, 0, 1'b0, done_cyc);
    check("basic_done_cycle", done_cyc, 18);
`ifdef TPU_SEQ_PERF_CNT_EN
    check("perf_after_done", cycle_count, 18);
    repeat (5) tick();
    check("perf_held_idle", cycle_count, 18);
`endif

    // Weight-FIFO empty for 5 cycles: whole timeline shifts by 5.
    run_tile("stall", 1'b0, 3, 10'h010, 10'h200, 5, 1'b0, done_cyc);
    check("stall_done_cycle", done_cyc, 23);

    // Weight reuse with address wrap and read/write overlap.
    run_tile("wrap", 1'b1, 20, 10'h3FE, 10'h3FF, 0, 1'b0, done_cyc);
    check("wrap_done_cycle", done_cyc, 33);

    // Zero rows: done next cycle, no strobes.
    run_tile("zero", 1'b0, 0, 10'h123, 10'h321, 0, 1'b0, done_cyc);
    check("zero_done_cycle", done_cyc, 1);

    // Start pulses mid-tile and in the done cycle are ignored.
    run_tile("ignore", 1'b0, 3, 10'h010, 10'h200, 0, 1'b1, done_cyc);
    check("ignore_done_cycle", done_cyc, 18);
    tick();

    // Reset during DRAIN: outputs clear at once, no done follows.
    start = 1'b1; weight_reuse = 1'b0; num_rows = 11'd3;
    src_base = 10'h010; dst_base = 10'h200; fifo_empty = 1'b0;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("rstmid_res_we_before", res_we, 1);
    rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rstmid_after_%0d_done", i), done, 0);
      check($sformatf("rstmid_after_%0d_res_we", i), res_we, 0);
    end
    run_tile("post_rst", 1'b0, 3, 10'h010, 10'h200, 0, 1'b0, done_cyc);
    check("post_rst_done_cycle", done_cyc, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
